mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- Parametrised memory arbiter that multiplexes NUM_CLIENTS request ports onto one single-port frame/command RAM.
- Client 0 is the data-fetcher port: it gets a guaranteed slot once every PRI_PERIOD cycles.
- Clients 1..NUM_CLIENTS-1 are drawing engines. They are served by a work-conserving round-robin that skips idle requesters.
- Read data is broadcast to all clients. A one-hot valid marks the owner of each return, RD_LATENCY cycles after the RAM is driven.

Parameters:
- NUM_CLIENTS, 4, total ports including client 0 (>=2)
- ADDR_W, 17, RAM address width
- DATA_W, 32, RAM data width
- WBEN_W, 4, byte write-enable width
- PRI_PERIOD, 2, client-0 guaranteed slot period in cycles (1 = strict priority)
- RD_LATENCY, 2, cycles from mem_* driven to mem_data_in valid (>=1)

Ports:
- clk  in  1  clock
- rst_  in  1  synchronous, active-high reset
- req_addr  in  NUM_CLIENTS*ADDR_W  per-client address, client i at slice i
- req_wrdata  in  NUM_CLIENTS*DATA_W  per-client write data
- req_op  in  NUM_CLIENTS*WBEN_W  per-client byte enables; all-ones = write, anything else = read
- req_rts  in  NUM_CLIENTS  request valid
- req_rtr  out  NUM_CLIENTS  grant (one-hot or zero)
- mem_wben  out  WBEN_W  RAM byte enables
- mem_addr  out  ADDR_W  RAM address
- mem_data_out  out  DATA_W  RAM write data
- mem_data_in  in  DATA_W  RAM read data
- bcast_data  out  DATA_W  mem_data_in passed through combinationally
- bcast_xfc  out  NUM_CLIENTS  one-hot read-return valid

Behaviour:
- Reset (rst_=1 at a clk edge): mem_wben, mem_addr, mem_data_out = 0; bcast_xfc = 0; read pipeline cleared; pri_cnt = 0; rr_ptr = client 1. req_rtr evaluates to 0 while rst_=1.
- pri_cnt is free-running: incremented every cycle, wrapping mod PRI_PERIOD.
- Grant is combinational from req_rts and state, evaluated in priority order:
  - (a) pri_cnt==0 and req_rts[0]: grant client 0.
  - (b) otherwise, the first client with req_rts set, searching from rr_ptr upward through 1..N-1 with wrap.
  - (c) otherwise, req_rts[0]: grant client 0 (fill slot).
  - (d) otherwise, no grant.
- Transfer on client i: req_rts[i] & req_rtr[i]. A client holds its request stable until it transfers.
- rr_ptr: after a transfer by client k>=1, rr_ptr = k+1, wrapping N-1 -> 1. Otherwise rr_ptr holds.
- Issue: in the cycle after a transfer, mem_* register the client's op, addr and wrdata.
- Idle cycle: mem_wben, mem_addr and mem_data_out are registered to 0. A zero mem_wben is treated as a read of address 0 with no owner.
- Reads:
  - A transfer whose op is not all-ones pushes the one-hot owner into a tag shift register RD_LATENCY+1 deep.
  - bcast_xfc[i] is asserted for exactly one cycle, RD_LATENCY cycles after mem_* carry that read.
  - Each read occupies its own pipeline slot, so back-to-back reads from different clients return in order.
- Writes (op all-ones) produce no broadcast.
- Reset asserted mid-operation: in-flight tags are discarded; no bcast_xfc fires for them.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt, NUM_CLIENTS*16 bits: per-client saturating transfer counters, cleared by reset.
  - Adds input stats_clr, which zeroes all counters synchronously; a transfer in the same cycle as stats_clr is not counted.
- When undefined: neither port exists and no counter logic is built.

Decomposition:
- Package arb_pkg holds:
  - default widths;
  - function is_write(op), which returns true when op is all-ones;
  - the one-hot/index conversion functions.
- Sub-module rr_pick: a combinational rotating-priority picker taking a request vector and a pointer, returning a one-hot grant. It is used for clients 1..N-1.

Test Plan (all with NUM_CLIENTS=4, PRI_PERIOD=2, RD_LATENCY=2):
- Reset: hold rst_=1 for 3 cycles with random requests -> all outputs 0 and req_rtr=0.
- Single read:
  - Stimulus: client 2 at addr 0x00123, op 4'h0, with mem_data_in modelled as a 2-cycle RAM.
  - req_rtr=4'b0100 in the same cycle. Next cycle, mem_addr=0x00123 and mem_wben=0.
  - bcast_xfc=4'b0100 with the RAM data exactly 3 cycles after the handshake.
- Write: client 1, addr 0x1FFFF, data 0xDEADBEEF, op 4'hF -> next cycle mem_wben=4'hF, mem_data_out=0xDEADBEEF; bcast_xfc stays 0.
- All four clients requesting continuously from reset -> grant order 0,1,0,2,0,3,0,1.
- Only client 0 requesting -> granted every cycle. Only client 3 requesting -> granted every cycle.
- Reset mid-flight:
  - Stimulus: a client 1 read, with rst_ pulsed 1 cycle after issue.
  - bcast_xfc never asserts. With ARB_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: default widths and small helpers shared by the memory arbiter.
// Helpers operate on fixed maximum-width vectors; callers zero-extend.
package arb_pkg;

    localparam int DEF_NUM_CLIENTS = 4;
    localparam int DEF_ADDR_W      = 17;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WBEN_W      = 4;
    localparam int DEF_PRI_PERIOD  = 2;
    localparam int DEF_RD_LATENCY  = 2;

    localparam int MAX_CLIENTS = 32;
    localparam int IDX_W       = 5;
    localparam int MAX_WBEN_W  = 64;

    // True when the low 'width' bits of op are all ones (a full write).
    function automatic logic is_write(input logic [MAX_WBEN_W-1:0] op, input int width);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < MAX_WBEN_W; i++) begin
            if (i < width && !op[i]) all_ones = 1'b0;
        end
        return all_ones;
    endfunction

    // Index of the set bit in a one-hot vector (zero when the vector is zero).
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CLIENTS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CLIENTS; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    // One-hot vector with only bit 'idx' set.
    function automatic logic [MAX_CLIENTS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_CLIENTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker. Searches i_req starting
// at position i_ptr upward with wrap and returns a one-hot grant (or zero).
module rr_pick
    import arb_pkg::*;
#(
    parameter int M = 3
) (
    input  logic [M-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [M-1:0]     o_gnt
);

    logic [2*M-1:0]  w_dbl;
    logic [M-1:0]    w_rot;
    logic            w_hit;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]  w_sum;
    logic [IDX_W:0]  w_abs;

    // Rotating the doubled vector puts the pointer position at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = M'(w_dbl >> i_ptr);

    // First requester at or after the pointer, as an offset from it.
    always_comb begin
        w_hit = 1'b0;
        w_off = '0;
        for (int j = 0; j < M; j++) begin
            if (!w_hit && w_rot[j]) begin
                w_hit = 1'b1;
                w_off = IDX_W'(j);
            end
        end
    end

    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign w_abs = (w_sum >= (IDX_W+1)'(M)) ? w_sum - (IDX_W+1)'(M) : w_sum;

    // Map the absolute winner position back to a one-hot grant.
    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < M; i++) begin
            o_gnt[i] = w_hit && (w_abs == (IDX_W+1)'(i));
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: multiplexes NUM_CLIENTS request ports onto one single-port
// RAM. Client 0 owns a guaranteed slot every PRI_PERIOD cycles; clients
// 1..N-1 share a work-conserving round-robin. Read returns are broadcast with
// a one-hot owner valid RD_LATENCY cycles after the RAM is driven.
// Optional macro ARB_STATS_EN adds per-client saturating grant counters.
module mem_arbiter_rr
    import arb_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WBEN_W      = DEF_WBEN_W,
    parameter int PRI_PERIOD  = DEF_PRI_PERIOD,
    parameter int RD_LATENCY  = DEF_RD_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_wrdata,
    input  logic [NUM_CLIENTS*WBEN_W-1:0] req_op,
    input  logic [NUM_CLIENTS-1:0]        req_rts,
    output logic [NUM_CLIENTS-1:0]        req_rtr,
    output logic [WBEN_W-1:0]             mem_wben,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data_out,
    input  logic [DATA_W-1:0]             mem_data_in,
    output logic [DATA_W-1:0]             bcast_data,
`ifdef ARB_STATS_EN
    input  logic                          stats_clr,
    output logic [NUM_CLIENTS*16-1:0]     grant_cnt,
`endif
    output logic [NUM_CLIENTS-1:0]        bcast_xfc
);

    localparam int PCW = (PRI_PERIOD > 1) ? $clog2(PRI_PERIOD) : 1;
    localparam int M   = NUM_CLIENTS - 1;

    logic [PCW-1:0]         r_pri_cnt;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [NUM_CLIENTS-1:0] r_tag_p [RD_LATENCY+1];

    logic [M-1:0]           w_rr_gnt;
    logic [NUM_CLIENTS-1:0] w_grant;
    logic [NUM_CLIENTS-1:0] w_xfc;
    logic [MAX_CLIENTS-1:0] w_xfc_ext;
    logic [IDX_W-1:0]       w_xfc_idx;
    logic [WBEN_W-1:0]      w_sel_op;
    logic [MAX_WBEN_W-1:0]  w_sel_op_ext;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_data;
    logic                   w_sel_rd;

    // Round-robin search over the drawing engines, pointer rebased to 0.
    rr_pick #(.M(M)) u_rr_pick (
        .i_req (req_rts[NUM_CLIENTS-1:1]),
        .i_ptr (r_rr_ptr - IDX_W'(1)),
        .o_gnt (w_rr_gnt)
    );

    // Grant: guaranteed client-0 slot, then round-robin, then client-0 fill.
    always_comb begin
        w_grant = '0;
        if (rst_) begin
            w_grant = '0;
        end else if (r_pri_cnt == '0 && req_rts[0]) begin
            w_grant[0] = 1'b1;
        end else if (|w_rr_gnt) begin
            w_grant[NUM_CLIENTS-1:1] = w_rr_gnt;
        end else if (req_rts[0]) begin
            w_grant[0] = 1'b1;
        end
    end

    assign req_rtr = w_grant;
    assign w_xfc   = req_rts & w_grant;

    // Select the transferring client's command fields.
    always_comb begin
        w_sel_op     = '0;
        w_sel_addr   = '0;
        w_sel_data   = '0;
        w_sel_op_ext = '0;
        w_xfc_ext    = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_xfc[i]) begin
                w_sel_op   = req_op[i*WBEN_W +: WBEN_W];
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_wrdata[i*DATA_W +: DATA_W];
            end
        end
        w_sel_op_ext[WBEN_W-1:0]   = w_sel_op;
        w_xfc_ext[NUM_CLIENTS-1:0] = w_xfc;
    end

    assign w_xfc_idx = onehot_to_idx(w_xfc_ext);
    assign w_sel_rd  = (|w_xfc) && !is_write(w_sel_op_ext, WBEN_W);

    // Free-running priority-slot counter, wraps mod PRI_PERIOD.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_pri_cnt <= '0;
        end else if (r_pri_cnt == PCW'(PRI_PERIOD - 1)) begin
            r_pri_cnt <= '0;
        end else begin
            r_pri_cnt <= r_pri_cnt + 1'b1;
        end
    end

    // Round-robin pointer moves past the last served drawing engine.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_rr_ptr <= IDX_W'(1);
        end else if (|w_xfc[NUM_CLIENTS-1:1]) begin
            r_rr_ptr <= (w_xfc_idx == IDX_W'(NUM_CLIENTS - 1)) ? IDX_W'(1)
                                                                : w_xfc_idx + IDX_W'(1);
        end
    end

    // Issue stage: register the winner's command, or all-zero when idle.
    always_ff @(posedge clk) begin
        if (rst_ || !(|w_xfc)) begin
            mem_wben     <= '0;
            mem_addr     <= '0;
            mem_data_out <= '0;
        end else begin
            mem_wben     <= w_sel_op;
            mem_addr     <= w_sel_addr;
            mem_data_out <= w_sel_data;
        end
    end

    // Read-owner tag pipeline; one slot per cycle keeps returns in order.
    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int i = 0; i <= RD_LATENCY; i++) r_tag_p[i] <= '0;
        end else begin
            r_tag_p[0] <= w_sel_rd ? w_xfc : '0;
            for (int i = 1; i <= RD_LATENCY; i++) r_tag_p[i] <= r_tag_p[i-1];
        end
    end

    assign bcast_xfc  = r_tag_p[RD_LATENCY];
    assign bcast_data = mem_data_in;

`ifdef ARB_STATS_EN
    logic [15:0] r_grant_cnt [NUM_CLIENTS];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    // Per-client saturating transfer counters; clear wins over a transfer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (rst_ || stats_clr) begin
                r_grant_cnt[i] <= '0;
            end else if (w_xfc[i]) begin
                r_grant_cnt[i] <= sat_inc(r_grant_cnt[i]);
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) grant_cnt[i*16 +: 16] = r_grant_cnt[i];
    end
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: table-driven grant vectors, directed read/write/reset
// sequences and randomized traffic checked against a behavioural model.
module tb_mem_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 17;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int PP = 2;
    localparam int RL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wrdata;
    logic [N*BW-1:0]   req_op;
    logic [N-1:0]      req_rts;
    logic [N-1:0]      req_rtr;
    logic [BW-1:0]     mem_wben;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data_out;
    logic [DW-1:0]     mem_data_in;
    logic [DW-1:0]     bcast_data;
    logic [N-1:0]      bcast_xfc;
`ifdef ARB_STATS_EN
    logic              stats_clr;
    logic [N*16-1:0]   grant_cnt;
    logic [15:0]       m_cnt [N];
`endif

    logic [AW-1:0] t_addr [N];
    logic [DW-1:0] t_data [N];
    logic [BW-1:0] t_op   [N];
    logic [N-1:0]  t_rts;

    always_comb begin
        req_rts = t_rts;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]   = t_addr[i];
            req_wrdata[i*DW +: DW] = t_data[i];
            req_op[i*BW +: BW]     = t_op[i];
        end
    end

    mem_arbiter_rr #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .WBEN_W(BW),
        .PRI_PERIOD(PP), .RD_LATENCY(RL)
    ) dut (
        .clk          (clk),
        .rst_         (rst_),
        .req_addr     (req_addr),
        .req_wrdata   (req_wrdata),
        .req_op       (req_op),
        .req_rts      (req_rts),
        .req_rtr      (req_rtr),
        .mem_wben     (mem_wben),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .bcast_data   (bcast_data),
`ifdef ARB_STATS_EN
        .stats_clr    (stats_clr),
        .grant_cnt    (grant_cnt),
`endif
        .bcast_xfc    (bcast_xfc)
    );

    // Two-cycle RAM: unwritten words read as a pattern derived from the address.
    function automatic logic [DW-1:0] ram_init(input logic [AW-1:0] a);
        return 32'hA5A5_0000 ^ {15'd0, a};
    endfunction

    logic [DW-1:0] ram [logic [AW-1:0]];
    logic [DW-1:0] rd_p1;
    always @(posedge clk) begin
        rd_p1       <= ram.exists(mem_addr) ? ram[mem_addr] : ram_init(mem_addr);
        mem_data_in <= rd_p1;
        if (mem_wben == 4'hF) ram[mem_addr] = mem_data_out;
    end

    // Reference model state.
    typedef struct { int due; logic [N-1:0] owner; logic [DW-1:0] data; } bc_t;
    bc_t           bq [$];
    logic [DW-1:0] mm [logic [AW-1:0]];
    int            m_pri;
    int            m_next;
    logic          m_valid;
    logic [BW-1:0] exp_wben;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_dout;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [N-1:0]  s_rtr, s_xfc;
    logic [BW-1:0] s_wben;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_dout, s_bdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mm_read(input logic [AW-1:0] a);
        return mm.exists(a) ? mm[a] : ram_init(a);
    endfunction

    // Grant rule: guaranteed slot, round-robin from m_next, then fill slot.
    function automatic logic [N-1:0] model_grant(input logic [N-1:0] rts);
        logic [N-1:0] g;
        int c;
        g = '0;
        if (m_pri == 0 && rts[0]) begin
            g[0] = 1'b1;
        end else begin
            for (int k = 0; k < N-1; k++) begin
                c = 1 + (m_next - 1 + k) % (N-1);
                if (g == '0 && rts[c]) g[c] = 1'b1;
            end
            if (g == '0 && rts[0]) g[0] = 1'b1;
        end
        return g;
    endfunction

    // One clock: drive, sample at negedge, compare with model, advance model.
    task automatic run_cycle(input logic rst_v);
        logic [N-1:0] eg;
        logic [N-1:0] ex;
        int k;
        rst_ = rst_v;
        @(negedge clk);
        s_rtr = req_rtr; s_wben = mem_wben; s_addr = mem_addr;
        s_dout = mem_data_out; s_xfc = bcast_xfc; s_bdata = bcast_data;
        eg = rst_v ? '0 : model_grant(t_rts);
        check("req_rtr", 64'(s_rtr), 64'(eg));
        if (m_valid) begin
            check("mem_wben", 64'(s_wben), 64'(exp_wben));
            check("mem_addr", 64'(s_addr), 64'(exp_addr));
            check("mem_data_out", 64'(s_dout), 64'(exp_dout));
            ex = (bq.size() > 0 && bq[0].due == cyc) ? bq[0].owner : '0;
            check("bcast_xfc", 64'(s_xfc), 64'(ex));
            if (ex != '0) begin
                check("bcast_data", 64'(s_bdata), 64'(bq[0].data));
                void'(bq.pop_front());
            end
`ifdef ARB_STATS_EN
            for (int c = 0; c < N; c++)
                check("grant_cnt", 64'(grant_cnt[c*16 +: 16]), 64'(m_cnt[c]));
`endif
        end
        if (rst_v) begin
            m_pri = 0; m_next = 1; m_valid = 1'b1;
            exp_wben = '0; exp_addr = '0; exp_dout = '0;
            bq.delete();
`ifdef ARB_STATS_EN
            for (int c = 0; c < N; c++) m_cnt[c] = '0;
`endif
        end else begin
            ex = t_rts & eg;
            k = -1;
            for (int c = 0; c < N; c++) if (ex[c]) k = c;
            exp_wben = '0; exp_addr = '0; exp_dout = '0;
            if (k >= 0) begin
                exp_wben = t_op[k]; exp_addr = t_addr[k]; exp_dout = t_data[k];
                if (t_op[k] == 4'hF) mm[t_addr[k]] = t_data[k];
                else bq.push_back('{due: cyc + 1 + RL, owner: ex, data: mm_read(t_addr[k])});
                if (k >= 1) m_next = (k == N-1) ? 1 : k + 1;
            end
`ifdef ARB_STATS_EN
            for (int c = 0; c < N; c++) begin
                if (stats_clr) m_cnt[c] = '0;
                else if (ex[c] && m_cnt[c] != 16'hFFFF) m_cnt[c] = m_cnt[c] + 16'd1;
            end
`endif
            m_pri = (m_pri + 1) % PP;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct { logic rst; logic [N-1:0] rts; logic [N-1:0] exp; } vec_t;
    vec_t vt [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic rv;
        m_valid = 1'b0; m_pri = 0; m_next = 1;
        exp_wben = '0; exp_addr = '0; exp_dout = '0;
        rst_ = 1'b1;
        t_rts = '0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
        for (int c = 0; c < N; c++) m_cnt[c] = '0;
`endif
        for (int i = 0; i < N; i++) begin
            t_addr[i] = AW'(i * 16); t_data[i] = '0; t_op[i] = '0;
        end

        // Reset with requests present, then grant-order patterns.
        vt.push_back('{1'b1, 4'hF, 4'h0});
        vt.push_back('{1'b1, 4'h5, 4'h0});
        vt.push_back('{1'b1, 4'hA, 4'h0});
        vt.push_back('{1'b0, 4'hF, 4'b0001});
        vt.push_back('{1'b0, 4'hF, 4'b0010});
        vt.push_back('{1'b0, 4'hF, 4'b0001});
        vt.push_back('{1'b0, 4'hF, 4'b0100});
        vt.push_back('{1'b0, 4'hF, 4'b0001});
        vt.push_back('{1'b0, 4'hF, 4'b1000});
        vt.push_back('{1'b0, 4'hF, 4'b0001});
        vt.push_back('{1'b0, 4'hF, 4'b0010});
        for (int i = 0; i < 4; i++) vt.push_back('{1'b0, 4'b0001, 4'b0001});
        for (int i = 0; i < 4; i++) vt.push_back('{1'b0, 4'b1000, 4'b1000});

        @(posedge clk);
        #1;
        for (int i = 0; i < vt.size(); i++) begin
            t_rts = vt[i].rts;
            run_cycle(vt[i].rst);
            check("vec_rtr", 64'(s_rtr), 64'(vt[i].exp));
            if (vt[i].rst && i > 0) begin
                check("rst_wben", 64'(s_wben), 64'(0));
                check("rst_addr", 64'(s_addr), 64'(0));
                check("rst_dout", 64'(s_dout), 64'(0));
                check("rst_xfc", 64'(s_xfc), 64'(0));
            end
        end

        t_rts = '0;
        repeat (4) run_cycle(1'b0);

        // Write from client 1: issued next cycle, never broadcast.
        t_addr[1] = 17'h1FFFF; t_data[1] = 32'hDEADBEEF; t_op[1] = 4'hF;
        t_rts = 4'b0010;
        run_cycle(1'b0);
        check("wr_rtr", 64'(s_rtr), 64'(4'b0010));
        t_rts = '0;
        run_cycle(1'b0);
        check("wr_wben", 64'(s_wben), 64'(4'hF));
        check("wr_addr", 64'(s_addr), 64'(17'h1FFFF));
        check("wr_dout", 64'(s_dout), 64'(32'hDEADBEEF));
        repeat (3) begin
            run_cycle(1'b0);
            check("wr_no_xfc", 64'(s_xfc), 64'(0));
        end

        // Single read from client 2, data returns 3 cycles after handshake.
        t_addr[2] = 17'h00123; t_op[2] = 4'h0;
        t_rts = 4'b0100;
        run_cycle(1'b0);
        check("rd_rtr", 64'(s_rtr), 64'(4'b0100));
        t_rts = '0;
        run_cycle(1'b0);
        check("rd_addr", 64'(s_addr), 64'(17'h00123));
        check("rd_wben", 64'(s_wben), 64'(0));
        run_cycle(1'b0);
        check("rd_early_xfc", 64'(s_xfc), 64'(0));
        run_cycle(1'b0);
        check("rd_xfc", 64'(s_xfc), 64'(4'b0100));
        check("rd_data", 64'(s_bdata), 64'(32'hA5A50123));

        // Read from client 1 with reset pulsed one cycle after issue.
        t_addr[1] = 17'h00055; t_op[1] = 4'h3;
        t_rts = 4'b0010;
        run_cycle(1'b0);
        t_rts = '0;
        run_cycle(1'b0);
        check("mf_addr", 64'(s_addr), 64'(17'h00055));
        run_cycle(1'b1);
        repeat (3) begin
            run_cycle(1'b0);
            check("mf_no_xfc", 64'(s_xfc), 64'(0));
`ifdef ARB_STATS_EN
            check("mf_cnt", 64'(grant_cnt), 64'(0));
`endif
        end

        // Random traffic; each client holds its request until it transfers.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!t_rts[i] && $urandom_range(0, 1) == 1) begin
                    t_rts[i]  = 1'b1;
                    t_addr[i] = AW'($urandom_range(0, 15));
                    t_op[i]   = ($urandom_range(0, 1) == 1) ? 4'hF : BW'($urandom_range(0, 14));
                    t_data[i] = $urandom;
                end
            end
            rv = ($urandom_range(0, 99) == 0);
`ifdef ARB_STATS_EN
            stats_clr = ($urandom_range(0, 63) == 0);
`endif
            run_cycle(rv);
            for (int i = 0; i < N; i++) if (s_rtr[i]) t_rts[i] = 1'b0;
        end
        t_rts = '0;
        repeat (5) run_cycle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
